// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: request/status bundle between a word producer and the UART transmitter.
//
// Signals:
//   tx_en_sig    send request, only honoured while the transmitter is idle
//   tx_data      word to send, captured when the request is accepted
//   tx_busy      frame in flight
//   tx_done_sig  one-cycle pulse after the last stop bit
//   tx           serial line, idles high
//
// Modports:
//   master  producer side (drives tx_en_sig/tx_data, observes status and line)
//   slave   transmitter side
interface uart_tx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_en_sig;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done_sig;
    logic                 tx;

    modport master (
        output tx_en_sig,
        output tx_data,
        input  tx_busy,
        input  tx_done_sig,
        input  tx
    );

    modport slave (
        input  tx_en_sig,
        input  tx_data,
        output tx_busy,
        output tx_done_sig,
        output tx
    );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with built-in baud divider.
//
// Frame: start bit, DATA_BITS data bits LSB first, optional odd/even parity bit, then
// STOP_BITS stop bits. Every bit lasts BAUD_DIV sysclk cycles. A request made in the
// tx_done_sig cycle is accepted, so frames can run back-to-back with a single idle cycle.
//
// Ports:
//   sysclk  system clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     uart_tx_param_if.slave (tx_en_sig, tx_data in; tx_busy, tx_done_sig, tx out)
//
// All outputs are registered.
module uart_tx_param #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic            sysclk,
    input  logic            rst_n,
    uart_tx_param_if.slave  bus
);

    localparam int unsigned BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned CNT_W    = (BAUD_DIV >= 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    // Configuration check, evaluated at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        BAUD_DIV < 2) begin : gen_cfg_err
        $error("uart_tx_param: illegal parameter configuration");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // tx is registered, so each bit-advance edge loads the value of the upcoming bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != StIdle) begin
            baud_d = baud_last ? '0 : baud_q + CNT_W'(1);
        end

        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.tx_en_sig) begin
                    state_d = StStart;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = bus.tx_data;
                    par_d   = (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
                end
            end
            StStart: begin
                if (baud_last) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (baud_last) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = StPar;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            StPar: begin
                if (baud_last) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            StStop: begin
                if (baud_last) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.tx          = tx_q;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_done_sig = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three instances (8N1, 7E2, 7O2), BAUD_DIV = 4.
module tb_uart_tx_param;

    logic sysclk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    uart_tx_param_if #(.DATA_BITS(8)) if8 ();
    uart_tx_param_if #(.DATA_BITS(7)) if7e ();
    uart_tx_param_if #(.DATA_BITS(7)) if7o ();

    uart_tx_param #(
        .CLK_FREQ (400),
        .BAUD     (100),
        .DATA_BITS(8),
        .PARITY   (0),
        .STOP_BITS(1)
    ) u_8n1 (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    uart_tx_param #(
        .CLK_FREQ (400),
        .BAUD     (100),
        .DATA_BITS(7),
        .PARITY   (2),
        .STOP_BITS(2)
    ) u_7e2 (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .bus   (if7e.slave)
    );

    uart_tx_param #(
        .CLK_FREQ (400),
        .BAUD     (100),
        .DATA_BITS(7),
        .PARITY   (1),
        .STOP_BITS(2)
    ) u_7o2 (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .bus   (if7o.slave)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // {tx, tx_busy, tx_done_sig}
    function automatic logic [2:0] obs(input int sel);
        case (sel)
            0:       obs = {if8.tx, if8.tx_busy, if8.tx_done_sig};
            1:       obs = {if7e.tx, if7e.tx_busy, if7e.tx_done_sig};
            default: obs = {if7o.tx, if7o.tx_busy, if7o.tx_done_sig};
        endcase
    endfunction

    // Entered on the first START cycle. bits[k] is the k-th bit on the line.
    // At cycle 'poke' of the frame (instance 0 only) a spurious request with data FF is made.
    task automatic run_frame(input int sel, input logic [15:0] bits, input int nb,
                             input int poke, input string tag);
        logic [2:0] o;
        for (int i = 0; i < nb * 4; i++) begin
            o = obs(sel);
            chk({tag, "_tx"}, o[2], bits[i / 4]);
            chk({tag, "_busy"}, o[1], 1'b1);
            chk({tag, "_done_early"}, o[0], 1'b0);
            if (sel == 0 && i == poke) begin
                if8.tx_en_sig = 1'b1;
                if8.tx_data   = 8'hFF;
            end
            if (sel == 0 && i == poke + 1) if8.tx_en_sig = 1'b0;
            step();
        end
        o = obs(sel);
        chk({tag, "_done"}, o[0], 1'b1);
        chk({tag, "_busy_end"}, o[1], 1'b0);
        chk({tag, "_tx_end"}, o[2], 1'b1);
    endtask

    task automatic quiet(input int sel, input int n, input string tag);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (obs(sel) !== 3'b100) bad = 1'b1;
            step();
        end
        chk(tag, bad, 1'b0);
    endtask

    initial begin
        logic [2:0] o;
        rst_n = 1'b0;
        if8.tx_en_sig  = 1'b0;
        if8.tx_data    = '0;
        if7e.tx_en_sig = 1'b0;
        if7e.tx_data   = '0;
        if7o.tx_en_sig = 1'b0;
        if7o.tx_data   = '0;

        // Reset and idle
        repeat (3) step();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            o = obs(s);
            chk("rst_tx", o[2], 1'b1);
            chk("rst_busy", o[1], 1'b0);
            chk("rst_done", o[0], 1'b0);
        end
        quiet(0, 100, "idle_quiet");

        // Single 8N1 frame, A5 -> 0,1,0,1,0,0,1,0,1,1
        if8.tx_data   = 8'hA5;
        if8.tx_en_sig = 1'b1;
        step();
        if8.tx_en_sig = 1'b0;
        run_frame(0, {6'b0, 10'b1101001010}, 10, 1000, "f8n1");
        step();
        o = obs(0);
        chk("f8n1_done_once", o[0], 1'b0);

        // 7E2, data 41 (two ones) -> parity 0, 44 cycles
        if7e.tx_data   = 7'h41;
        if7e.tx_en_sig = 1'b1;
        step();
        if7e.tx_en_sig = 1'b0;
        run_frame(1, {5'b0, 2'b11, 1'b0, 7'h41, 1'b0}, 11, 1000, "f7e2");
        step();
        o = obs(1);
        chk("f7e2_done_once", o[0], 1'b0);

        // 7O2, same data -> parity 1
        if7o.tx_data   = 7'h41;
        if7o.tx_en_sig = 1'b1;
        step();
        if7o.tx_en_sig = 1'b0;
        run_frame(2, {5'b0, 2'b11, 1'b1, 7'h41, 1'b0}, 11, 1000, "f7o2");
        step();
        o = obs(2);
        chk("f7o2_done_once", o[0], 1'b0);

        // Back-to-back: request held high, data changed after first acceptance
        if8.tx_data   = 8'h55;
        if8.tx_en_sig = 1'b1;
        step();
        if8.tx_data = 8'h0F;
        run_frame(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 1000, "b2b_a");
        step();
        if8.tx_en_sig = 1'b0;
        o = obs(0);
        chk("b2b_gap_tx", o[2], 1'b0);
        chk("b2b_gap_busy", o[1], 1'b1);
        run_frame(0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 1000, "b2b_b");
        step();
        o = obs(0);
        chk("b2b_done_once", o[0], 1'b0);
        chk("b2b_idle_after", o[1], 1'b0);

        // Ignored request while busy, data changed mid-frame
        if8.tx_data   = 8'h3C;
        if8.tx_en_sig = 1'b1;
        step();
        if8.tx_en_sig = 1'b0;
        run_frame(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 10, "ign");
        step();
        quiet(0, 12, "ign_no_extra");

        // Reset during data bit 3 (line bit 4, cycles 16..19 of the frame)
        if8.tx_data   = 8'h96;
        if8.tx_en_sig = 1'b1;
        step();
        if8.tx_en_sig = 1'b0;
        repeat (17) step();
        o = obs(0);
        chk("mid_tx_bit3", o[2], 1'b0);
        chk("mid_busy", o[1], 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        o = obs(0);
        chk("mrst_tx", o[2], 1'b1);
        chk("mrst_busy", o[1], 1'b0);
        chk("mrst_done", o[0], 1'b0);
        quiet(0, 60, "mrst_quiet");
        if8.tx_data   = 8'hC3;
        if8.tx_en_sig = 1'b1;
        step();
        if8.tx_en_sig = 1'b0;
        run_frame(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 1000, "post_rst");
        step();
        o = obs(0);
        chk("post_rst_done_once", o[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
